fpu_fpr_wb_sched: RTL and testbench
===================================

Name: fpu_fpr_wb_sched

Overview:
- Write-back scheduler and scoreboard for the 32-entry FP register file.
- Arbitrates three write-back sources onto the regfile's single write port (wen0/waddr0/wd0) with round-robin fairness: 0 = FMA/add pipe, 1 = FP load return, 2 = div/sqrt unit.
- Tracks a busy bit per FP register between issue-time allocation and write-back.
- Raises a RAW stall for the decode stage and blocks WAW allocation.

Parameters:
- FPLEN, 32, data width of an FP register.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- alloc_valid  in  1  decode issues an instruction that writes an FP destination.
- alloc_addr  in  5  destination FP register of the issuing instruction.
- alloc_ready  out  1  allocation accepted (destination not busy).
- rden0, rden1, rden2  in  1 each  source operand read enables.
- raddr0, raddr1, raddr2  in  5 each  source operand addresses.
- raw_stall  out  1  some enabled source is busy.
- wb0_valid, wb1_valid, wb2_valid  in  1 each  write-back request.
- wb0_addr, wb1_addr, wb2_addr  in  5 each  write-back destination.
- wb0_data, wb1_data, wb2_data  in  FPLEN each  write-back data.
- wb0_ready, wb1_ready, wb2_ready  out  1 each  request granted this cycle.
- wen0  out  1  regfile write enable (registered).
- waddr0  out  5  regfile write address (registered).
- wd0  out  FPLEN  regfile write data (registered).
- busy_cnt  out  6  number of busy registers (0..32).
- sb_err  out  1  one-cycle pulse: write-back to a non-busy register.

Behaviour:
- Reset (async, rst=1):
  - wen0=0, waddr0=0, wd0=0, busy[31:0]=0, busy_cnt=0, sb_err=0.
  - RR pointer last=2, so requester 0 has top priority first.
- Arbitration is combinational in the request cycle.
  - Priority order: last+1, last+2, last (mod 3).
  - The first valid requester in that order gets wbN_ready=1; the others get 0.
  - Requester N holds wbN_valid/addr/data stable until wbN_ready=1.
  - last updates to the granted index on the clock edge only when a grant occurs. No grant leaves last unchanged.
- Output stage, at the grant edge:
  - wen0 <= |grant.
  - waddr0/wd0 <= granted addr/data. Hold previous values when there is no grant.
  - Regfile write latency: exactly 1 cycle after the grant cycle.
  - Throughput: 1 write per cycle, with no bubble between back-to-back grants.
- Scoreboard:
  - busy[a] clears on the edge that ends a cycle with wen0=1 and waddr0=a. This is the same edge at which the regfile stores the data.
  - Set condition: alloc_valid & alloc_ready sets busy[alloc_addr] on the edge.
  - alloc_ready = ~busy[alloc_addr]. There is no forwarding of a clear in the same cycle, so set and clear of the same address never coincide. Set and clear of different addresses apply together.
  - raw_stall = |(rdenK & busy[raddrK]) over K = 0..2. It is combinational and uses the current busy vector. A register is readable the cycle after its wen0 cycle.
  - busy_cnt is registered: +1 on a set, -1 on a clear, net 0 when both happen.
- Error check:
  - If wen0=1 and busy[waddr0]=0, sb_err pulses for that cycle.
  - The regfile write still occurs and busy is unchanged.
- All 32 FP registers are ordinary; there is no hardwired-zero register.
- Reset mid-operation discards any granted-but-unwritten data (wen0 forced 0) and clears all busy bits. Requesters must re-issue.

Decomposition:
- Shared package fpu_pkg:
  - FPR_ADDR_W=5, NUM_FPR=32, NUM_WB_SRC=3.
  - Source index constants WB_SRC_FMA=0, WB_SRC_LOAD=1, WB_SRC_DIV=2.
- One sub-module: fpu_rr_arb3. It takes valid[2:0] and last[1:0], and outputs a one-hot grant[2:0] and the granted index. It is purely combinational.
- The scoreboard, counter and output register stay in the top module.

Test Plan:
- Reset then idle: no requests for 5 cycles → wen0=0, busy_cnt=0, raw_stall=0, all wbN_ready=0.
- Allocate f5, read it, write it back:
  - alloc_valid, alloc_addr=5 → busy[5]=1, busy_cnt=1.
  - rden1=1, raddr1=5 → raw_stall=1.
  - wb1 writes f5 with data 0x3F800000, granted cycle T → wen0=1, waddr0=5, wd0=0x3F800000 at T+1.
  - raw_stall=0 and busy_cnt=0 at T+2.
- All three requesters valid continuously from reset, addresses 1/2/3 pre-allocated → grant sequence 0,1,2,0,…, with wen0 high every cycle.
- WAW block: f7 busy, alloc_addr=7 → alloc_ready=0 and busy_cnt unchanged. Repeat the same alloc in the cycle after f7's wen0 cycle → alloc_ready=1.
- Same-cycle set and clear: f3 clearing via wen0 while alloc_addr=9 is accepted → busy[3]=0, busy[9]=1, busy_cnt unchanged.
- Spurious write-back: wb2 writes to f12 with busy[12]=0 → wen0=1, sb_err=1 for one cycle, busy_cnt unchanged. Assert rst during a granted cycle → wen0=0 immediately and busy cleared.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FP-unit constants: register-file geometry and write-back source indices.
package fpu_pkg;

  localparam int unsigned FPR_ADDR_W = 5;
  localparam int unsigned NUM_FPR    = 32;
  localparam int unsigned NUM_WB_SRC = 3;

  localparam logic [1:0] WB_SRC_FMA  = 2'd0;
  localparam logic [1:0] WB_SRC_LOAD = 2'd1;
  localparam logic [1:0] WB_SRC_DIV  = 2'd2;

endpackage

// File: rtl/fpu_rr_arb3.sv
// Combinational 3-way round-robin arbiter; the requester after 'last' has top priority.
module fpu_rr_arb3
  import fpu_pkg::*;
(
  input  logic [NUM_WB_SRC-1:0] valid,
  input  logic [1:0]            last,
  output logic [NUM_WB_SRC-1:0] grant,
  output logic [1:0]            idx
);

  logic [1:0] order [NUM_WB_SRC];
  logic       found;

  always_comb begin
    order[0] = WB_SRC_FMA;
    order[1] = WB_SRC_LOAD;
    order[2] = WB_SRC_DIV;
    unique case (last)
      2'd0: begin
        order[0] = WB_SRC_LOAD;
        order[1] = WB_SRC_DIV;
        order[2] = WB_SRC_FMA;
      end
      2'd1: begin
        order[0] = WB_SRC_DIV;
        order[1] = WB_SRC_FMA;
        order[2] = WB_SRC_LOAD;
      end
      default: ;
    endcase
  end

  always_comb begin
    grant = '0;
    idx   = last;
    found = 1'b0;
    for (int k = 0; k < NUM_WB_SRC; k++) begin
      if (!found && valid[order[k]]) begin
        found = 1'b1;
        idx   = order[k];
        grant = 3'b001 << order[k];
      end
    end
  end

endmodule

// File: rtl/fpu_fpr_wb_sched.sv
// FP register-file write-back scheduler: round-robin write port arbitration plus
// a per-register busy scoreboard driving RAW stalls and WAW allocation blocking.
module fpu_fpr_wb_sched
  import fpu_pkg::*;
#(
  parameter int unsigned FPLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  input  logic [FPR_ADDR_W-1:0] alloc_addr,
  output logic                  alloc_ready,
  input  logic                  rden0,
  input  logic                  rden1,
  input  logic                  rden2,
  input  logic [FPR_ADDR_W-1:0] raddr0,
  input  logic [FPR_ADDR_W-1:0] raddr1,
  input  logic [FPR_ADDR_W-1:0] raddr2,
  output logic                  raw_stall,
  input  logic                  wb0_valid,
  input  logic                  wb1_valid,
  input  logic                  wb2_valid,
  input  logic [FPR_ADDR_W-1:0] wb0_addr,
  input  logic [FPR_ADDR_W-1:0] wb1_addr,
  input  logic [FPR_ADDR_W-1:0] wb2_addr,
  input  logic [FPLEN-1:0]      wb0_data,
  input  logic [FPLEN-1:0]      wb1_data,
  input  logic [FPLEN-1:0]      wb2_data,
  output logic                  wb0_ready,
  output logic                  wb1_ready,
  output logic                  wb2_ready,
  output logic                  wen0,
  output logic [FPR_ADDR_W-1:0] waddr0,
  output logic [FPLEN-1:0]      wd0,
  output logic [5:0]            busy_cnt,
  output logic                  sb_err
);

  logic [NUM_WB_SRC-1:0] wb_valid;
  logic [FPR_ADDR_W-1:0] wb_addr [NUM_WB_SRC];
  logic [FPLEN-1:0]      wb_data [NUM_WB_SRC];
  logic [NUM_WB_SRC-1:0] grant;
  logic [1:0]            gnt_idx;
  logic [1:0]            last_q;
  logic [NUM_FPR-1:0]    busy_q, busy_d;
  logic                  set_en, clr_en;

  always_comb begin
    wb_valid              = {wb2_valid, wb1_valid, wb0_valid};
    wb_addr[WB_SRC_FMA]   = wb0_addr;
    wb_addr[WB_SRC_LOAD]  = wb1_addr;
    wb_addr[WB_SRC_DIV]   = wb2_addr;
    wb_data[WB_SRC_FMA]   = wb0_data;
    wb_data[WB_SRC_LOAD]  = wb1_data;
    wb_data[WB_SRC_DIV]   = wb2_data;
  end

  fpu_rr_arb3 u_arb (
    .valid (wb_valid),
    .last  (last_q),
    .grant (grant),
    .idx   (gnt_idx)
  );

  assign wb0_ready = grant[WB_SRC_FMA];
  assign wb1_ready = grant[WB_SRC_LOAD];
  assign wb2_ready = grant[WB_SRC_DIV];

  // No same-cycle forwarding of a clear: a register is allocatable only once busy drops.
  assign alloc_ready = ~busy_q[alloc_addr];
  assign set_en      = alloc_valid & alloc_ready;
  assign clr_en      = wen0 & busy_q[waddr0];
  assign sb_err      = wen0 & ~busy_q[waddr0];
  assign raw_stall   = (rden0 & busy_q[raddr0]) | (rden1 & busy_q[raddr1]) |
                       (rden2 & busy_q[raddr2]);

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[waddr0] = 1'b0;
    if (set_en) busy_d[alloc_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q   <= WB_SRC_DIV;
      wen0     <= 1'b0;
      waddr0   <= '0;
      wd0      <= '0;
      busy_q   <= '0;
      busy_cnt <= '0;
    end else begin
      wen0   <= |grant;
      busy_q <= busy_d;
      if (|grant) begin
        last_q <= gnt_idx;
        waddr0 <= wb_addr[gnt_idx];
        wd0    <= wb_data[gnt_idx];
      end
      if (set_en && !clr_en) begin
        busy_cnt <= busy_cnt + 6'd1;
      end else if (clr_en && !set_en) begin
        busy_cnt <= busy_cnt - 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_fpr_wb_sched.sv
// Directed self-checking bench for the FP write-back scheduler and scoreboard.
module tb_fpu_fpr_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid, alloc_ready;
  logic [4:0]  alloc_addr;
  logic        rden0, rden1, rden2;
  logic [4:0]  raddr0, raddr1, raddr2;
  logic        raw_stall;
  logic        wb0_valid, wb1_valid, wb2_valid;
  logic [4:0]  wb0_addr, wb1_addr, wb2_addr;
  logic [31:0] wb0_data, wb1_data, wb2_data;
  logic        wb0_ready, wb1_ready, wb2_ready;
  logic        wen0;
  logic [4:0]  waddr0;
  logic [31:0] wd0;
  logic [5:0]  busy_cnt;
  logic        sb_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fpu_fpr_wb_sched #(.FPLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .alloc_ready (alloc_ready),
    .rden0       (rden0),
    .rden1       (rden1),
    .rden2       (rden2),
    .raddr0      (raddr0),
    .raddr1      (raddr1),
    .raddr2      (raddr2),
    .raw_stall   (raw_stall),
    .wb0_valid   (wb0_valid),
    .wb1_valid   (wb1_valid),
    .wb2_valid   (wb2_valid),
    .wb0_addr    (wb0_addr),
    .wb1_addr    (wb1_addr),
    .wb2_addr    (wb2_addr),
    .wb0_data    (wb0_data),
    .wb1_data    (wb1_data),
    .wb2_data    (wb2_data),
    .wb0_ready   (wb0_ready),
    .wb1_ready   (wb1_ready),
    .wb2_ready   (wb2_ready),
    .wen0        (wen0),
    .waddr0      (waddr0),
    .wd0         (wd0),
    .busy_cnt    (busy_cnt),
    .sb_err      (sb_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rdy();
    return {29'd0, wb2_ready, wb1_ready, wb0_ready};
  endfunction

  initial begin
    rst = 1'b1;
    alloc_valid = 0; alloc_addr = 0;
    rden0 = 0; rden1 = 0; rden2 = 0; raddr0 = 0; raddr1 = 0; raddr2 = 0;
    wb0_valid = 0; wb1_valid = 0; wb2_valid = 0;
    wb0_addr = 0; wb1_addr = 0; wb2_addr = 0;
    wb0_data = 0; wb1_data = 0; wb2_data = 0;
    step(); step();
    check("rst_wen0", {31'd0, wen0}, 0);
    check("rst_waddr0", {27'd0, waddr0}, 0);
    check("rst_wd0", wd0, 0);
    check("rst_busy_cnt", {26'd0, busy_cnt}, 0);
    check("rst_sb_err", {31'd0, sb_err}, 0);
    rst = 1'b0;

    // Idle with all read ports enabled: nothing busy, nothing granted.
    rden0 = 1; rden1 = 1; rden2 = 1; raddr0 = 5; raddr1 = 17; raddr2 = 31;
    repeat (5) step();
    check("idle_wen0", {31'd0, wen0}, 0);
    check("idle_busy_cnt", {26'd0, busy_cnt}, 0);
    check("idle_raw_stall", {31'd0, raw_stall}, 0);
    check("idle_ready", rdy(), 0);
    rden0 = 0; rden1 = 0; rden2 = 0;

    // Allocate f5, observe the RAW stall, then write it back from the load port.
    alloc_valid = 1; alloc_addr = 5;
    #1 check("f5_alloc_ready", {31'd0, alloc_ready}, 1);
    step();
    alloc_valid = 0;
    check("f5_busy_cnt", {26'd0, busy_cnt}, 1);
    rden1 = 1; raddr1 = 5;
    #1 check("f5_raw_stall", {31'd0, raw_stall}, 1);
    wb1_valid = 1; wb1_addr = 5; wb1_data = 32'h3F80_0000;
    #1 check("f5_wb1_grant", rdy(), 3'b010);
    step();
    wb1_valid = 0;
    check("f5_wen0", {31'd0, wen0}, 1);
    check("f5_waddr0", {27'd0, waddr0}, 5);
    check("f5_wd0", wd0, 32'h3F80_0000);
    check("f5_sb_err", {31'd0, sb_err}, 0);
    check("f5_stall_in_wen", {31'd0, raw_stall}, 1);
    step();
    check("f5_stall_clear", {31'd0, raw_stall}, 0);
    check("f5_busy_cnt0", {26'd0, busy_cnt}, 0);
    check("f5_wen0_off", {31'd0, wen0}, 0);
    rden1 = 0;

    // Fresh reset so the round-robin pointer restarts; pre-allocate f1..f3.
    rst = 1; step(); rst = 0;
    for (int a = 1; a <= 3; a++) begin
      alloc_valid = 1; alloc_addr = a[4:0];
      step();
    end
    alloc_valid = 0;
    check("rr_busy_cnt3", {26'd0, busy_cnt}, 3);
    wb0_valid = 1; wb0_addr = 1; wb0_data = 32'hA0;
    wb1_valid = 1; wb1_addr = 2; wb1_data = 32'hA1;
    wb2_valid = 1; wb2_addr = 3; wb2_data = 32'hA2;
    #1 check("rr_g0", rdy(), 3'b001);
    step();
    check("rr_w0_addr", {27'd0, waddr0}, 1);
    check("rr_w0_data", wd0, 32'hA0);
    check("rr_g1", rdy(), 3'b010);
    step();
    check("rr_w1_wen", {31'd0, wen0}, 1);
    check("rr_w1_addr", {27'd0, waddr0}, 2);
    check("rr_g2", rdy(), 3'b100);
    step();
    check("rr_w2_wen", {31'd0, wen0}, 1);
    check("rr_w2_addr", {27'd0, waddr0}, 3);
    check("rr_w2_data", wd0, 32'hA2);
    check("rr_g0_again", rdy(), 3'b001);
    step();
    wb0_valid = 0; wb1_valid = 0; wb2_valid = 0;
    // f1 was already cleared, so the repeat write is spurious.
    check("rr_w3_addr", {27'd0, waddr0}, 1);
    check("rr_w3_sb_err", {31'd0, sb_err}, 1);
    check("rr_busy_cnt0", {26'd0, busy_cnt}, 0);
    step();

    // WAW: f7 busy blocks a second allocation until the cycle after its write.
    alloc_valid = 1; alloc_addr = 7;
    step();
    #1 check("waw_blocked", {31'd0, alloc_ready}, 0);
    step();
    check("waw_cnt_hold", {26'd0, busy_cnt}, 1);
    wb0_valid = 1; wb0_addr = 7; wb0_data = 32'h77;
    step();
    wb0_valid = 0;
    check("waw_wen0", {31'd0, wen0}, 1);
    check("waw_no_fwd", {31'd0, alloc_ready}, 0);
    step();
    check("waw_cnt_clr", {26'd0, busy_cnt}, 0);
    check("waw_ready", {31'd0, alloc_ready}, 1);
    step();
    alloc_valid = 0;
    check("waw_cnt_set", {26'd0, busy_cnt}, 1);

    // Same-cycle set of f9 and clear of f3.
    alloc_valid = 1; alloc_addr = 3;
    step();
    alloc_valid = 0;
    check("sc_cnt2", {26'd0, busy_cnt}, 2);
    wb0_valid = 1; wb0_addr = 3; wb0_data = 32'h33;
    step();
    wb0_valid = 0;
    alloc_valid = 1; alloc_addr = 9;
    #1 check("sc_alloc9_ready", {31'd0, alloc_ready}, 1);
    step();
    alloc_valid = 0;
    check("sc_cnt_same", {26'd0, busy_cnt}, 2);
    rden0 = 1; raddr0 = 3;
    #1 check("sc_f3_free", {31'd0, raw_stall}, 0);
    rden0 = 0; rden2 = 1; raddr2 = 9;
    #1 check("sc_f9_busy", {31'd0, raw_stall}, 1);
    rden2 = 0;

    // Spurious write-back of f12 from the div/sqrt port.
    wb2_valid = 1; wb2_addr = 12; wb2_data = 32'hC0C0;
    #1 check("sp_grant", rdy(), 3'b100);
    step();
    wb2_valid = 0;
    check("sp_wen0", {31'd0, wen0}, 1);
    check("sp_sb_err", {31'd0, sb_err}, 1);
    step();
    check("sp_sb_err_off", {31'd0, sb_err}, 0);
    check("sp_cnt", {26'd0, busy_cnt}, 2);

    // Reset asserted while a granted write is on the port.
    wb2_valid = 1;
    step();
    wb2_valid = 0;
    check("mr_wen0_pre", {31'd0, wen0}, 1);
    #1 rst = 1;
    #1;
    check("mr_wen0", {31'd0, wen0}, 0);
    check("mr_cnt", {26'd0, busy_cnt}, 0);
    rden0 = 1; raddr0 = 7; rden1 = 1; raddr1 = 9;
    #1 check("mr_busy_clear", {31'd0, raw_stall}, 0);
    step();
    rst = 0;
    rden0 = 0; rden1 = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
